// File: rtl/fft_out_serializer_if.sv
// fft_out_serializer_if: frame capture and bin streaming signals of the FFT
// output unloader. The slave modport is the serializer's view, the master
// modport is the view of the logic feeding frames in and taking bins out.
interface fft_out_serializer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] dr0, dr1, dr2, dr3, dr4, dr5, dr6, dr7;
  logic signed [15:0] di0, di1, di2, di3, di4, di5, di6, di7;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic [2:0]         out_idx;
  logic               out_last;
  logic               drop;

  modport slave (
    input  in_valid,
    input  dr0, dr1, dr2, dr3, dr4, dr5, dr6, dr7,
    input  di0, di1, di2, di3, di4, di5, di6, di7,
    input  out_ready,
    output in_ready,
    output out_valid, out_re, out_im, out_idx, out_last,
    output drop
  );

  modport master (
    output in_valid,
    output dr0, dr1, dr2, dr3, dr4, dr5, dr6, dr7,
    output di0, di1, di2, di3, di4, di5, di6, di7,
    output out_ready,
    input  in_ready,
    input  out_valid, out_re, out_im, out_idx, out_last,
    input  drop
  );
endinterface

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures a whole 8-bin complex frame in one cycle into
// one of two ping-pong banks and streams the bins out in order 0..7 over a
// valid/ready interface while the other bank can accept the next frame.
// Optional build macro FFT_OUT_SCALE_EN: outputs are scaled by 1/8 with
// round-half-up on the output mux; the stored data stay unscaled.
module fft_out_serializer (
  input logic                 clk,
  input logic                 rst,
  fft_out_serializer_if.slave bus
);

  logic signed [15:0] bank_re [2][8];
  logic signed [15:0] bank_im [2][8];
  logic [1:0]         full;
  logic               wr_sel;
  logic               rd_sel;
  logic [2:0]         idx;
  logic               drop;

  logic signed [15:0] in_re [8];
  logic signed [15:0] in_im [8];
  logic [1:0]         full_next;
  logic               wr_sel_next;
  logic               rd_sel_next;
  logic [2:0]         idx_next;
  logic               in_ready;
  logic               out_valid;
  logic               capture;
  logic               xfer;
  logic signed [15:0] rd_re;
  logic signed [15:0] rd_im;

`ifdef FFT_OUT_SCALE_EN
  // (x + 4) >>> 3 in 17 bits: divide by 8 rounding half up; result fits in 14 bits
  function automatic logic signed [15:0] scale_out(input logic signed [15:0] x);
    logic signed [16:0] wide;
    logic signed [16:0] shifted;
    wide    = {x[15], x} + 17'sd4;
    shifted = wide >>> 3;
    return shifted[15:0];
  endfunction
`endif

  // in_ready depends only on registers, so capture never forms a loop with in_valid
  assign in_ready  = ~full[wr_sel];
  assign out_valid = full[rd_sel];
  assign capture   = bus.in_valid & in_ready;
  assign xfer      = out_valid & bus.out_ready;

  // Gather the sixteen frame inputs into bin-indexed arrays for the bank write
  always_comb begin
    in_re[0] = bus.dr0;  in_im[0] = bus.di0;
    in_re[1] = bus.dr1;  in_im[1] = bus.di1;
    in_re[2] = bus.dr2;  in_im[2] = bus.di2;
    in_re[3] = bus.dr3;  in_im[3] = bus.di3;
    in_re[4] = bus.dr4;  in_im[4] = bus.di4;
    in_re[5] = bus.dr5;  in_im[5] = bus.di5;
    in_re[6] = bus.dr6;  in_im[6] = bus.di6;
    in_re[7] = bus.dr7;  in_im[7] = bus.di7;
  end

  // Next-state for bank flags, pointers and bin index; capture and last transfer
  // always touch different banks, so both may act in the same cycle
  always_comb begin
    full_next   = full;
    wr_sel_next = wr_sel;
    rd_sel_next = rd_sel;
    idx_next    = idx;
    if (capture) begin
      full_next[wr_sel] = 1'b1;
      wr_sel_next       = ~wr_sel;
    end else begin
      wr_sel_next = wr_sel;
    end
    if (xfer) begin
      idx_next = idx + 3'd1;
      if (idx == 3'd7) begin
        full_next[rd_sel] = 1'b0;
        rd_sel_next       = ~rd_sel;
      end else begin
        rd_sel_next = rd_sel;
      end
    end else begin
      idx_next = idx;
    end
  end

  // Control registers and the registered drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      idx    <= 3'd0;
      drop   <= 1'b0;
    end else begin
      full   <= full_next;
      wr_sel <= wr_sel_next;
      rd_sel <= rd_sel_next;
      idx    <= idx_next;
      drop   <= bus.in_valid & ~in_ready;
    end
  end

  // Bank storage: a whole frame lands in the write bank on capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          bank_re[b][k] <= 16'sd0;
          bank_im[b][k] <= 16'sd0;
        end
      end
    end else if (capture) begin
      for (int k = 0; k < 8; k++) begin
        bank_re[wr_sel][k] <= in_re[k];
        bank_im[wr_sel][k] <= in_im[k];
      end
    end
  end

  // Output mux: current bin of the read bank; driven purely from registers
  always_comb begin
    rd_re = bank_re[rd_sel][idx];
    rd_im = bank_im[rd_sel][idx];
`ifdef FFT_OUT_SCALE_EN
    bus.out_re = scale_out(rd_re);
    bus.out_im = scale_out(rd_im);
`else
    bus.out_re = rd_re;
    bus.out_im = rd_im;
`endif
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = idx;
  assign bus.out_last  = out_valid & (idx == 3'd7);
  assign bus.drop      = drop;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: directed and random stimulus against a bin-queue
// reference model of the ping-pong FFT output serializer.
module tb_fft_out_serializer;

  logic clk = 1'b0;
  logic rst;
  fft_out_serializer_if bus ();

  fft_out_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int drop_seen = 0;
  int q_re[$];
  int q_im[$];
  int q_idx[$];
  int frame_re[8];
  int frame_im[8];
  int got_re[8];
  int got_im[8];
  bit exp_drop = 1'b0;
  int d0;

  // Expected output component for a stored value
  function automatic int scale_ref(input int v);
`ifdef FFT_OUT_SCALE_EN
    return (v + 4) >>> 3;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic apply_frame();
    bus.dr0 = 16'(frame_re[0]); bus.di0 = 16'(frame_im[0]);
    bus.dr1 = 16'(frame_re[1]); bus.di1 = 16'(frame_im[1]);
    bus.dr2 = 16'(frame_re[2]); bus.di2 = 16'(frame_im[2]);
    bus.dr3 = 16'(frame_re[3]); bus.di3 = 16'(frame_im[3]);
    bus.dr4 = 16'(frame_re[4]); bus.di4 = 16'(frame_im[4]);
    bus.dr5 = 16'(frame_re[5]); bus.di5 = 16'(frame_im[5]);
    bus.dr6 = 16'(frame_re[6]); bus.di6 = 16'(frame_im[6]);
    bus.dr7 = 16'(frame_re[7]); bus.di7 = 16'(frame_im[7]);
  endtask

  task automatic random_frame();
    for (int k = 0; k < 8; k++) begin
      frame_re[k] = int'($urandom_range(0, 65535)) - 32768;
      frame_im[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    apply_frame();
  endtask

  task automatic clear_got();
    for (int k = 0; k < 8; k++) begin
      got_re[k] = 99999;
      got_im[k] = 99999;
    end
  endtask

  // One clock cycle: entered just after a falling edge with inputs set.
  // Checks outputs against the model, then advances the model across the edge.
  task automatic cycle();
    bit ev;
    bit er;
    bit exp_valid;
    int held;
    #1;
    exp_valid = (q_re.size() > 0);
    held      = (q_re.size() + 7) / 8;
    chk("out_valid", bus.out_valid, exp_valid);
    chk("in_ready", bus.in_ready, (held < 2));
    chk("drop", bus.drop, exp_drop);
    if (exp_valid) begin
      chk("out_re", $signed(bus.out_re), scale_ref(q_re[0]));
      chk("out_im", $signed(bus.out_im), scale_ref(q_im[0]));
      chk("out_idx", bus.out_idx, q_idx[0]);
      chk("out_last", bus.out_last, (q_idx[0] == 7));
    end else begin
      chk("out_last_idle", bus.out_last, 1'b0);
    end
    if (bus.drop === 1'b1) drop_seen++;
    ev = bus.in_valid;
    er = bus.out_ready;
    if (exp_valid && er) begin
      got_re[q_idx[0]] = $signed(bus.out_re);
      got_im[q_idx[0]] = $signed(bus.out_im);
    end
    @(posedge clk);
    if (exp_valid && er) begin
      void'(q_re.pop_front());
      void'(q_im.pop_front());
      void'(q_idx.pop_front());
    end
    exp_drop = ev && !(held < 2);
    if (ev && (held < 2)) begin
      for (int k = 0; k < 8; k++) begin
        q_re.push_back(frame_re[k]);
        q_im.push_back(frame_im[k]);
        q_idx.push_back(k);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      frame_re[k] = 0;
      frame_im[k] = 0;
    end
    apply_frame();
    clear_got();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_idx", bus.out_idx, 3'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_re", $signed(bus.out_re), 0);
    chk("rst_out_im", $signed(bus.out_im), 0);
    chk("rst_drop", bus.drop, 1'b0);
    @(negedge clk);

    // Ramp frame: re = 100k, im = -k, drained with out_ready high
    for (int k = 0; k < 8; k++) begin
      frame_re[k] = 100 * k;
      frame_im[k] = -k;
    end
    apply_frame();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (10) cycle();
    chk("ramp_re7", got_re[7], scale_ref(700));
    chk("ramp_im7", got_im[7], scale_ref(-7));
    chk("ramp_re1", got_re[1], scale_ref(100));

    // Three back-to-back frames with output stalled: third is dropped
    bus.out_ready = 1'b0;
    d0 = drop_seen;
    bus.in_valid = 1'b1;
    repeat (3) begin
      random_frame();
      cycle();
    end
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    chk("abc_drop_count", drop_seen - d0, 1);
    bus.out_ready = 1'b1;
    repeat (18) cycle();

    // Random output stalls on a frame carrying extreme values in bin 3
    clear_got();
    random_frame();
    frame_re[3] = -32768;
    frame_im[3] = 32767;
    apply_frame();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'($urandom_range(0, 1));
    cycle();
    bus.in_valid = 1'b0;
    repeat (40) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.out_ready = 1'b1;
    repeat (10) cycle();
    chk("ext_re3", got_re[3], scale_ref(-32768));
    chk("ext_im3", got_im[3], scale_ref(32767));

    // Capture on the same edge as the previous frame's last transfer
    bus.out_ready = 1'b1;
    random_frame();
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (7) cycle();
    random_frame();
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (10) cycle();

    // Asynchronous reset mid-frame with the second bank full
    random_frame();
    bus.in_valid = 1'b1;
    cycle();
    random_frame();
    cycle();
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    #1;
    chk("pre_rst_idx", bus.out_idx, 3'd4);
    chk("pre_rst_in_ready", bus.in_ready, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_out_idx", bus.out_idx, 3'd0);
    q_re.delete();
    q_im.delete();
    q_idx.delete();
    exp_drop = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Scaling corner values on bins 0..3 (identical on re and im)
    clear_got();
    random_frame();
    frame_re[0] = 20;     frame_im[0] = 20;
    frame_re[1] = -20;    frame_im[1] = -20;
    frame_re[2] = 32767;  frame_im[2] = 32767;
    frame_re[3] = -32768; frame_im[3] = -32768;
    apply_frame();
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (10) cycle();
`ifdef FFT_OUT_SCALE_EN
    chk("scl_re0", got_re[0], 3);
    chk("scl_re1", got_re[1], -2);
    chk("scl_re2", got_re[2], 4096);
    chk("scl_re3", got_re[3], -4096);
    chk("scl_im0", got_im[0], 3);
    chk("scl_im1", got_im[1], -2);
    chk("scl_im2", got_im[2], 4096);
    chk("scl_im3", got_im[3], -4096);
`else
    chk("raw_re0", got_re[0], 20);
    chk("raw_re1", got_re[1], -20);
    chk("raw_re2", got_re[2], 32767);
    chk("raw_re3", got_re[3], -32768);
    chk("raw_im2", got_im[2], 32767);
    chk("raw_im3", got_im[3], -32768);
`endif

    // Random traffic on both sides
    repeat (300) begin
      random_frame();
      bus.in_valid  = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Output unloader for the 8-point FFT datapath. Captures one complete 8-bin complex frame from the stage-3 butterfly outputs in a single cycle and streams the bins out one per transfer, in natural order 0..7, over a valid/ready interface. A ping-pong double buffer lets the next frame be captured while the current frame drains.

## Interface
- No parameters. Width is fixed at 16-bit signed real and 16-bit signed imaginary per bin, 8 bins.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a frame is present on dr*/di* this cycle.
- in_ready  out  1  a buffer bank is free, so the frame will be captured.
- dr0..dr7, di0..di7  in  16 each, signed  real and imaginary part of bin k (k = 0..7).
- out_valid  out  1  out_re/out_im/out_idx carry a valid bin.
- out_ready  in  1  downstream accepts the bin.
- out_re, out_im  out  16 each, signed  current bin, scaled if FFT_OUT_SCALE_EN is defined.
- out_idx  out  3  bin index of current output.
- out_last  out  1  out_valid && out_idx==7.
- drop  out  1  one-cycle pulse: in_valid was high while in_ready was low, so the frame is lost.

## Operation
- Storage: two banks, each holding 8 × (re, im). State: full[1:0], wr_sel, rd_sel, idx[2:0].
- in_ready = ~full[wr_sel]. It is a function of registers only; there is no combinational path from in_valid.
- Capture occurs on in_valid && in_ready:
  - all 16 inputs are written into bank wr_sel;
  - full[wr_sel] is set;
  - wr_sel toggles.
- out_valid = full[rd_sel]. out_re/out_im = bank[rd_sel][idx] (scaled per Configuration). out_idx = idx.
- Transfer occurs on out_valid && out_ready:
  - idx increments.
  - If idx was 7: full[rd_sel] clears, rd_sel toggles, and idx wraps to 0.
- Stall: while out_valid && !out_ready, every out_* signal holds stable.
- Simultaneous capture and last transfer on different banks are both performed in the same edge.
- A bank freed by a last transfer is not visible to in_ready until the following cycle, because in_ready is evaluated on pre-edge state.
- drop is registered. It is high for the cycle after any edge where in_valid && !in_ready. The frame is discarded and no state changes.
- Both banks full: in_ready=0. Both banks empty: out_valid=0, and out_re/out_im show stale bank contents, which are don't-care.

## Timing
- Reset values (asynchronous):
  - full=00, wr_sel=0, rd_sel=0, idx=0, drop=0, all bank entries 0;
  - therefore in_ready=1, out_valid=0, out_idx=0, out_last=0, out_re=out_im=0.
- Latency: capture at edge e gives out_valid=1 in the cycle after e, presenting bin 0 (provided the read bank is the captured bank).
- Throughput: 1 bin/cycle with out_ready held high, i.e. 8 cycles per frame.
  - Input may sustain 1 frame per 8 cycles with no drops once in steady state.
  - Back-to-back frames on consecutive cycles: the first two are accepted and the third is dropped unless a bank has freed.
- Output ordering is strictly FIFO by frame. Bins within a frame always come out 0..7 with no gaps except stalls.
- Reset asserted mid-frame: all state clears immediately. Partially streamed and buffered frames are discarded, and out_valid drops asynchronously.

## Configuration
- FFT_OUT_SCALE_EN:
  - Defined: each output component = (x + 4) >>> 3, computed in 17 bits (1/N normalisation, round-half-up). The result fits in 14 bits and is sign-extended to 16.
  - Undefined: out_re/out_im = stored value unchanged.
  - Scaling applies on the output mux only. Storage is always unscaled.

## Test plan
- Reset, then frame with drk=100·k, dik=−k, in_valid 1 cycle, out_ready=1 → out_valid from next cycle for 8 cycles; out_re=0,100..700; out_im=0,−1..−7; out_last only with idx 7; then out_valid=0.
- Three frames A, B, C on consecutive cycles, out_ready=0 → A and B captured, in_ready=0 after the second, drop pulses once for C. Then release out_ready → 16 bins A0..A7, B0..B7.
- Random out_ready toggling on frame dr3=−32768, di3=32767 → each bin is presented until accepted, no duplicates or skips; bin 3 = (−32768, 32767) unscaled.
- Frame captured on the same edge as the last transfer of the previous frame (other bank) → both take effect; the new frame's bin 0 follows bin 7 with no bubble.
- Reset pulse while out_idx=4 with the second bank full → out_valid=0, in_ready=1, out_idx=0 asynchronously. The next frame streams from bin 0.
- With FFT_OUT_SCALE_EN defined:
  - dr0=20 gives 3; dr1=−20 gives −2; dr2=32767 gives 4096; dr3=−32768 gives −4096.
  - di equal to those values gives identical results.
